// File: rtl/spike_decoder.sv
// Delta-modulation spike decoder: UP/DN spikes step a saturating signed accumulator,
// sampled every CLK_DIV cycles onto a valid/ready output. Optional decay: SPIKE_DECODER_LEAK_EN.
module spike_decoder #(
  parameter int                         DATA_W     = 32,
  parameter int                         CLK_DIV    = 1200000,
  parameter logic signed [DATA_W-1:0]   INIT_VAL   = '0,
  parameter int                         LEAK_SHIFT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic              up_spike_i,
  input  logic              dn_spike_i,
  input  logic [DATA_W-1:0] delta_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              drop_o,
  output logic              sat_o
);

`ifdef SPIKE_DECODER_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // Two guard bits: delta is unsigned full width, so acc+delta can exceed DATA_W+1 signed.
  localparam int              EXT_W    = DATA_W + 2;
  localparam logic signed [EXT_W-1:0]  EXT_MAX = {{3{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  EXT_MIN = {{3{1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_div_cnt;
  logic signed [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]         r_sample;
  logic                      r_valid;
  logic                      r_drop;
  logic                      r_sat;

  logic                      w_run;
  logic                      w_tick;
  logic                      w_up;
  logic                      w_dn;
  logic signed [DATA_W:0]    w_acc_x;
  logic signed [DATA_W:0]    w_init_x;
  logic signed [DATA_W:0]    w_diff;
  logic signed [DATA_W:0]    w_decay;
  logic signed [DATA_W:0]    w_decayed;
  logic signed [EXT_W-1:0]   w_base_x;
  logic signed [EXT_W-1:0]   w_delta_x;
  logic signed [EXT_W-1:0]   w_sum;
  logic                      w_hi;
  logic                      w_lo;
  logic signed [DATA_W-1:0]  w_next;

  assign w_run  = (r_state == S_RUN);
  assign w_tick = w_run && (r_div_cnt == CNT_LAST);
  assign w_up   = up_spike_i & ~dn_spike_i;
  assign w_dn   = dn_spike_i & ~up_spike_i;

  // Decay toward INIT_VAL happens first on a tick; the spike step is applied on top.
  always_comb begin
    w_acc_x   = {r_acc[DATA_W-1], r_acc};
    w_init_x  = {INIT_VAL[DATA_W-1], INIT_VAL};
    w_diff    = w_acc_x - w_init_x;
    w_decay   = w_diff >>> LEAK_SHIFT;
    w_decayed = w_acc_x - w_decay;
    w_base_x  = (LEAK_ON && w_tick) ? EXT_W'(w_decayed) : EXT_W'(w_acc_x);
    w_delta_x = {2'b00, delta_i};
    w_sum     = w_base_x;
    if (w_up)      w_sum = w_base_x + w_delta_x;
    else if (w_dn) w_sum = w_base_x - w_delta_x;
    w_hi   = (w_sum > EXT_MAX);
    w_lo   = (w_sum < EXT_MIN);
    w_next = w_sum[DATA_W-1:0];
    if (w_hi)      w_next = SAT_MAX;
    else if (w_lo) w_next = SAT_MIN;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_acc     <= INIT_VAL;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (enable_i)  r_state <= S_RUN;
        S_RUN:  if (!enable_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (!w_run || !enable_i || w_tick) r_div_cnt <= '0;
      else                               r_div_cnt <= r_div_cnt + CNT_W'(1);

      if (load_i)     r_acc <= INIT_VAL;
      else if (w_run) r_acc <= w_next;

      if (load_i)                 r_sat <= 1'b0;
      else if (w_run && (w_hi || w_lo)) r_sat <= 1'b1;

      // Capture uses the pre-update accumulator; a tick beats a same-cycle transfer.
      if (w_tick) begin
        r_sample <= r_acc;
        r_valid  <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid  <= 1'b0;
      end

      if (load_i)                             r_drop <= 1'b0;
      else if (w_tick && r_valid && !ready_i) r_drop <= 1'b1;
    end
  end

  assign sample_o = r_sample;
  assign valid_o  = r_valid;
  assign drop_o   = r_drop;
  assign sat_o    = r_sat;

endmodule
